// File: rtl/b_filter_stream_core.sv
// RGB-to-luma pixel filter with optional threshold binarisation and per-frame hit statistics.
// Two-stage pipeline, latency 2; downstream stalls hold both stages, and s_axis_tready drops once both are full.
module b_filter_stream_core #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              ctrl_enable,
    input  logic              ctrl_bypass,
    input  logic [7:0]        ctrl_threshold,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic [CNT_W-1:0]  stat_frame_cnt,
    output logic [CNT_W-1:0]  stat_hit_cnt
);

    localparam logic [7:0]       PIX_MAX     = 8'hFF;
    localparam logic [7:0]       THR_RST     = 8'h80;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             rst_meta_q;
    logic             rst_sync_q;
    logic             rst_n;

    logic             shd_byp_q,  shd_byp_d;
    logic [7:0]       shd_thr_q,  shd_thr_d;

    logic             st1_vld_q,  st1_vld_d;
    logic [7:0]       st1_y_q,    st1_y_d;
    logic             st1_byp_q,  st1_byp_d;
    logic [7:0]       st1_thr_q,  st1_thr_d;
    logic             st1_user_q, st1_user_d;
    logic             st1_last_q, st1_last_d;

    logic             st2_vld_q,  st2_vld_d;
    logic [7:0]       st2_dat_q,  st2_dat_d;
    logic             st2_user_q, st2_user_d;
    logic             st2_last_q, st2_last_d;

    logic [CNT_W-1:0] live_q,     live_d;
    logic [CNT_W-1:0] hit_q,      hit_d;
    logic [CNT_W-1:0] frame_q,    frame_d;

    logic             st2_load;
    logic             st1_load;
    logic             in_acc;
    logic             sof_acc;
    logic             out_acc;
    logic             cfg_byp;
    logic [7:0]       cfg_thr;
    logic [15:0]      luma_sum;
    logic [7:0]       luma_y;
    logic [7:0]       filt_dat;

    // Release is retimed to ACLK; assertion stays asynchronous.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    assign st2_load      = m_axis_tready || !st2_vld_q;
    assign st1_load      = !st1_vld_q || st2_load;
    assign s_axis_tready = ctrl_enable && rst_n && st1_load;
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign sof_acc       = in_acc && s_axis_tuser;
    assign out_acc       = st2_vld_q && m_axis_tready;

    // The SOF beat itself must see the freshly captured configuration.
    assign cfg_byp = sof_acc ? ctrl_bypass    : shd_byp_q;
    assign cfg_thr = sof_acc ? ctrl_threshold : shd_thr_q;

    // Weights sum to 256, so the 16-bit sum cannot overflow and Y never saturates.
    assign luma_sum = 16'(s_axis_tdata[23:16]) * 16'd77
                    + 16'(s_axis_tdata[15:8])  * 16'd150
                    + 16'(s_axis_tdata[7:0])   * 16'd29;
    assign luma_y   = 8'(luma_sum >> 8);

    assign filt_dat = st1_byp_q ? st1_y_q
                                : ((st1_y_q >= st1_thr_q) ? PIX_MAX : 8'h00);

    always_comb begin
        shd_byp_d = shd_byp_q;
        shd_thr_d = shd_thr_q;
        if (sof_acc) begin
            shd_byp_d = ctrl_bypass;
            shd_thr_d = ctrl_threshold;
        end
    end

    always_comb begin
        st1_vld_d  = st1_vld_q;
        st1_y_d    = st1_y_q;
        st1_byp_d  = st1_byp_q;
        st1_thr_d  = st1_thr_q;
        st1_user_d = st1_user_q;
        st1_last_d = st1_last_q;
        if (st1_load) begin
            st1_vld_d = in_acc;
        end
        if (in_acc) begin
            st1_y_d    = luma_y;
            st1_byp_d  = cfg_byp;
            st1_thr_d  = cfg_thr;
            st1_user_d = s_axis_tuser;
            st1_last_d = s_axis_tlast;
        end
    end

    always_comb begin
        st2_vld_d  = st2_vld_q;
        st2_dat_d  = st2_dat_q;
        st2_user_d = st2_user_q;
        st2_last_d = st2_last_q;
        if (st2_load) begin
            st2_vld_d = st1_vld_q;
            if (st1_vld_q) begin
                st2_dat_d  = filt_dat;
                st2_user_d = st1_user_q;
                st2_last_d = st1_last_q;
            end
        end
    end

    // The SOF beat opens the new frame, so it seeds the live count rather than adding to the old one.
    always_comb begin
        live_d  = live_q;
        hit_d   = hit_q;
        frame_d = frame_q;
        if (out_acc) begin
            if (st2_user_q) begin
                hit_d   = live_q;
                live_d  = (st2_dat_q == PIX_MAX) ? CNT_ONE : '0;
                frame_d = frame_q + CNT_ONE;
            end else if (st2_dat_q == PIX_MAX) begin
                live_d  = live_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            shd_byp_q  <= 1'b1;
            shd_thr_q  <= THR_RST;
            st1_vld_q  <= 1'b0;
            st1_y_q    <= 8'h00;
            st1_byp_q  <= 1'b1;
            st1_thr_q  <= THR_RST;
            st1_user_q <= 1'b0;
            st1_last_q <= 1'b0;
            st2_vld_q  <= 1'b0;
            st2_dat_q  <= 8'h00;
            st2_user_q <= 1'b0;
            st2_last_q <= 1'b0;
            live_q     <= '0;
            hit_q      <= '0;
            frame_q    <= '0;
        end else begin
            shd_byp_q  <= shd_byp_d;
            shd_thr_q  <= shd_thr_d;
            st1_vld_q  <= st1_vld_d;
            st1_y_q    <= st1_y_d;
            st1_byp_q  <= st1_byp_d;
            st1_thr_q  <= st1_thr_d;
            st1_user_q <= st1_user_d;
            st1_last_q <= st1_last_d;
            st2_vld_q  <= st2_vld_d;
            st2_dat_q  <= st2_dat_d;
            st2_user_q <= st2_user_d;
            st2_last_q <= st2_last_d;
            live_q     <= live_d;
            hit_q      <= hit_d;
            frame_q    <= frame_d;
        end
    end

    assign m_axis_tvalid  = st2_vld_q;
    assign m_axis_tdata   = st2_dat_q;
    assign m_axis_tuser   = st2_user_q;
    assign m_axis_tlast   = st2_last_q;
    assign stat_frame_cnt = frame_q;
    assign stat_hit_cnt   = hit_q;

endmodule
